shift_reg: RTL and testbench

//   Mode-controlled parallel-load / rotate register, WIDTH bits, one clock domain.
//   A 2-bit mode selects load, rotate-left, rotate-right or hold, gated by an enable.

---
 rtl/shift_reg_pkg.sv | 12 +
 rtl/shift_reg.sv | 42 ++++
 tb/tb_shift_reg.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the mode-controlled load/rotate register.
// The dir field encoding lives here so the RTL and any wrappers use the same codes.
package shift_reg_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_LOAD = 2'b00;
    localparam dir_t DIR_ROL  = 2'b01;
    localparam dir_t DIR_ROR  = 2'b10;
    localparam dir_t DIR_HOLD = 2'b11;

endpackage

// File: rtl/shift_reg.sv
// WIDTH-bit parallel-load / rotate register with asynchronous active-low clear.
// out is taken straight from the flops, so there is no input-to-output path.
module shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  dir_t             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    // An unknown en falls to the hold path, so X control never loads fresh data.
    always_comb begin
        out_d = out_q;
        if (en) begin
            case (dir)
                DIR_LOAD: out_d = d;
                DIR_ROL:  out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                DIR_ROR:  out_d = {out_q[0], out_q[WIDTH-1:1]};
                default:  out_d = out_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg: directed vector table, async reset cases,
// and randomized traffic against an arithmetic reference model (WIDTH 8 and 4).
module tb_shift_reg;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [1:0] dir;
    logic [7:0] d;
    logic [7:0] out8;
    logic [3:0] out4;

    int n_cmp = 0;
    int n_err = 0;

    shift_reg #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .dir  (dir),
        .d    (d),
        .out  (out8)
    );

    shift_reg #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .dir  (dir),
        .d    (d[3:0]),
        .out  (out4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        bit         en;
        bit [1:0]   dir;
        bit [7:0]   d;
        bit [7:0]   exp8;
        bit [3:0]   exp4;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit e, input bit [1:0] op, input bit [7:0] dv);
        @(negedge clk);
        en  = e;
        dir = op;
        d   = dv;
        @(posedge clk);
        #1;
    endtask

    // Reference: rotation by shifts and masks on a plain integer value.
    function automatic logic [31:0] ref_next(input logic [31:0] v, input bit e,
                                             input bit [1:0] op, input logic [31:0] dv,
                                             input int w);
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        if (!e) return v;
        case (op)
            2'd0:    return dv & mask;
            2'd1:    return ((v << 1) | (v >> (w - 1))) & mask;
            2'd2:    return ((v >> 1) | ((v & 32'h1) << (w - 1))) & mask;
            default: return v;
        endcase
    endfunction

    logic [31:0] m8;
    logic [31:0] m4;

    initial begin
        rstn = 1'b0;
        en   = 1'b1;
        dir  = 2'b00;
        d    = 8'hFF;

        // Reset held across several edges with a pending LOAD of FF.
        #1;
        check("reset_async", 32'(out8), 32'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold8[%0d]", i), 32'(out8), 32'h00);
            check($sformatf("reset_hold4[%0d]", i), 32'(out4), 32'h0);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release8", 32'(out8), 32'hFF);
        check("reset_release4", 32'(out4), 32'hF);

        // Directed vectors: name, en, dir, d, expected 8-bit, expected 4-bit.
        tbl.push_back('{"rol_load", 1'b1, 2'b00, 8'h01, 8'h01, 4'h1});
        tbl.push_back('{"rol1", 1'b1, 2'b01, 8'h00, 8'h02, 4'h2});
        tbl.push_back('{"rol2", 1'b1, 2'b01, 8'h00, 8'h04, 4'h4});
        tbl.push_back('{"rol3", 1'b1, 2'b01, 8'h00, 8'h08, 4'h8});
        tbl.push_back('{"rol4", 1'b1, 2'b01, 8'h00, 8'h10, 4'h1});
        tbl.push_back('{"rol5", 1'b1, 2'b01, 8'h00, 8'h20, 4'h2});
        tbl.push_back('{"rol6", 1'b1, 2'b01, 8'h00, 8'h40, 4'h4});
        tbl.push_back('{"rol7", 1'b1, 2'b01, 8'h00, 8'h80, 4'h8});
        tbl.push_back('{"rol8_wrap", 1'b1, 2'b01, 8'h00, 8'h01, 4'h1});
        tbl.push_back('{"ror_load", 1'b1, 2'b00, 8'h01, 8'h01, 4'h1});
        tbl.push_back('{"ror1_wrap", 1'b1, 2'b10, 8'h00, 8'h80, 4'h8});
        tbl.push_back('{"ror2", 1'b1, 2'b10, 8'h00, 8'h40, 4'h4});
        tbl.push_back('{"ror3", 1'b1, 2'b10, 8'h00, 8'h20, 4'h2});
        tbl.push_back('{"ror_a5_load", 1'b1, 2'b00, 8'hA5, 8'hA5, 4'h5});
        tbl.push_back('{"ror_a5", 1'b1, 2'b10, 8'h00, 8'hD2, 4'hA});
        tbl.push_back('{"hold_load", 1'b1, 2'b00, 8'h3C, 8'h3C, 4'hC});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{$sformatf("hold_en0_%0d", i), 1'b0, 2'b01, 8'hFF, 8'h3C, 4'hC});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{$sformatf("hold_dir_%0d", i), 1'b1, 2'b11, 8'hFF, 8'h3C, 4'hC});
        tbl.push_back('{"sw_load", 1'b1, 2'b00, 8'h96, 8'h96, 4'h6});
        tbl.push_back('{"sw_rol", 1'b1, 2'b01, 8'h00, 8'h2D, 4'hC});
        tbl.push_back('{"sw_ror", 1'b1, 2'b10, 8'h00, 8'h96, 4'h6});
        tbl.push_back('{"sw_hold", 1'b1, 2'b11, 8'h00, 8'h96, 4'h6});
        tbl.push_back('{"fix0_load", 1'b1, 2'b00, 8'h00, 8'h00, 4'h0});
        tbl.push_back('{"fix0_rol", 1'b1, 2'b01, 8'hFF, 8'h00, 4'h0});
        tbl.push_back('{"fix1_load", 1'b1, 2'b00, 8'hFF, 8'hFF, 4'hF});
        tbl.push_back('{"fix1_ror", 1'b1, 2'b10, 8'h00, 8'hFF, 4'hF});

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].dir, tbl[i].d);
            check({tbl[i].name, "_w8"}, 32'(out8), 32'(tbl[i].exp8));
            check({tbl[i].name, "_w4"}, 32'(out4), 32'(tbl[i].exp4));
        end

        // Async clear between edges while rotating 81.
        step(1'b1, 2'b00, 8'h81);
        check("async_load", 32'(out8), 32'h81);
        step(1'b1, 2'b01, 8'h00);
        check("async_rol", 32'(out8), 32'h03);
        #1;
        rstn = 1'b0;
        #1;
        check("async_clear8", 32'(out8), 32'h00);
        check("async_clear4", 32'(out4), 32'h0);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b01, 8'h00);
            check($sformatf("async_after_rol[%0d]", i), 32'(out8), 32'h00);
        end

        // Randomized traffic against the reference model.
        m8 = 32'(out8 === 8'h00 ? 8'h00 : 8'hxx);
        m4 = 32'h0;
        for (int i = 0; i < 400; i++) begin
            bit       e;
            bit [1:0] op;
            bit [7:0] dv;
            e  = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            dv = 8'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #1;
                rstn = 1'b0;
                #1;
                rstn = 1'b1;
                m8 = 32'h0;
                m4 = 32'h0;
                check($sformatf("rand_async8[%0d]", i), 32'(out8), m8);
            end
            step(e, op, dv);
            m8 = ref_next(m8, e, op, 32'(dv), 8);
            m4 = ref_next(m4, e, op, 32'(dv[3:0]), 4);
            check($sformatf("rand_w8[%0d]", i), 32'(out8), m8);
            check($sformatf("rand_w4[%0d]", i), 32'(out4), m4);
        end

        // Full-width rotate round trips on a random value.
        begin
            bit [7:0] seed;
            seed = 8'($urandom);
            step(1'b1, 2'b00, seed);
            for (int k = 0; k < 8; k++) step(1'b1, 2'b01, 8'h00);
            check("rol_roundtrip", 32'(out8), 32'(seed));
            for (int k = 0; k < 8; k++) step(1'b1, 2'b10, 8'h00);
            check("ror_roundtrip", 32'(out8), 32'(seed));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
